hazard_sched: RTL

Pipeline hazard and stall scheduler for the 5-stage ARM core. Each cycle it decides whether the ID stage must insert a bubble (RAW hazard) and whether the whole pipeline must freeze on a slow data-memory access. It also decides whether IF/ID must be flushed on a taken branch. It drives the `hazard` input of the ID stage, the freeze enables of the PC and pipeline registers, and a sticky memory-timeout flag and stall counter for debug.

---
 rtl/arm_pkg.sv | 13 +
 rtl/hazard_sched_reg_match.sv | 19 +
 rtl/hazard_sched.sv | 113 +++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM core pipeline control blocks.
// FSM state type, register-index width and default memory timeout.
package arm_pkg;

    localparam int REG_IDX_W       = 4;
    localparam int MEM_TIMEOUT_DEF = 64;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        WAIT = 1'b1
    } sched_state_t;

endpackage

// File: rtl/hazard_sched_reg_match.sv
// Source/destination register comparator for the hazard scheduler.
// Flags a hit when an enabled ID source names an enabled destination.
module reg_match
    import arm_pkg::*;
(
    input  logic [REG_IDX_W-1:0] src1,
    input  logic                 src1_en,
    input  logic [REG_IDX_W-1:0] src2,
    input  logic                 two_src,
    input  logic [REG_IDX_W-1:0] dest,
    input  logic                 dest_en,
    output logic                 hit
);

    assign hit = dest_en &
                 ((src1_en & (src1 == dest)) |
                  (two_src & (src2 == dest)));

endmodule

// File: rtl/hazard_sched.sv
// Pipeline hazard, flush and memory-freeze scheduler with timeout watchdog.
// Define HAZARD_SCHED_FWD_EN when a forwarding unit is present (load-use only).
module hazard_sched
    import arm_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_src1,
    input  logic                 id_src1_en,
    input  logic [REG_IDX_W-1:0] id_src2,
    input  logic                 id_two_src,
    input  logic [REG_IDX_W-1:0] exe_dest,
    input  logic                 exe_wb_en,
    input  logic                 exe_mem_r_en,
    input  logic [REG_IDX_W-1:0] mem_dest,
    input  logic                 mem_wb_en,
    input  logic                 exe_branch,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    output logic                 hazard,
    output logic                 freeze_all,
    output logic                 flush,
    output logic                 mem_timeout,
    output logic [CNT_W-1:0]     stall_count
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

    sched_state_t      state;
    logic [WCNT_W-1:0] wcnt;
    logic              exe_hit;
    logic              exe_dest_en;
    logic              raw_hz;

`ifdef HAZARD_SCHED_FWD_EN
    // Only a load in EXE cannot be forwarded in time.
    assign exe_dest_en = exe_wb_en & exe_mem_r_en;
`else
    assign exe_dest_en = exe_wb_en;
`endif

    reg_match u_exe_match (
        .src1    (id_src1),
        .src1_en (id_src1_en),
        .src2    (id_src2),
        .two_src (id_two_src),
        .dest    (exe_dest),
        .dest_en (exe_dest_en),
        .hit     (exe_hit)
    );

`ifdef HAZARD_SCHED_FWD_EN
    assign raw_hz = exe_hit;
`else
    logic mem_hit;

    reg_match u_mem_match (
        .src1    (id_src1),
        .src1_en (id_src1_en),
        .src2    (id_src2),
        .two_src (id_two_src),
        .dest    (mem_dest),
        .dest_en (mem_wb_en),
        .hit     (mem_hit)
    );

    assign raw_hz = exe_hit | mem_hit;
`endif

    assign freeze_all = rst & mem_req & ~mem_ready;
    assign flush      = rst & exe_branch & ~freeze_all;
    assign hazard     = rst & raw_hz & ~freeze_all & ~flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= RUN;
            wcnt        <= '0;
            mem_timeout <= 1'b0;
            stall_count <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (freeze_all) begin
                        state <= WAIT;
                        wcnt  <= WCNT_W'(1);
                    end
                end
                WAIT: begin
                    if (mem_ready || !mem_req) begin
                        state <= RUN;
                        wcnt  <= '0;
                    end else begin
                        if (wcnt != WCNT_MAX)
                            wcnt <= wcnt + WCNT_W'(1);
                        if (wcnt == WCNT_MAX)
                            mem_timeout <= 1'b1;
                    end
                end
                default: begin
                    state <= RUN;
                    wcnt  <= '0;
                end
            endcase
            if ((hazard || freeze_all) && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule
